// File: rtl/store_buffer_if.sv
// Interface bundling the core store port, the load-forwarding lookup, the dmem
// write port and the occupancy status of store_buffer.
//   master : core/dmem side; drives st_valid/st_addr/st_data, ld_addr, mem_ack
//   slave  : store_buffer side; drives st_ready, ld_hit/ld_data,
//            mem_we/mem_addr/mem_wd, count, empty
`timescale 1ns/1ps
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
);
    logic                         st_valid;
    logic [AW-1:0]                st_addr;
    logic [DW-1:0]                st_data;
    logic                         st_ready;
    logic [AW-1:0]                ld_addr;
    logic                         ld_hit;
    logic [DW-1:0]                ld_data;
    logic                         mem_we;
    logic [AW-1:0]                mem_addr;
    logic [DW-1:0]                mem_wd;
    logic                         mem_ack;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         empty;

    modport master (
        output st_valid, st_addr, st_data, ld_addr, mem_ack,
        input  st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wd, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, mem_ack,
        output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wd, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and dmem. Stores are queued and
// drained in program order over a valid/ack handshake; loads look up the queue
// combinationally and the youngest word-matching entry forwards its data.
// Ports:
//   clk   : system clock, all state updates on posedge
//   reset : synchronous, active-high; discards all pending stores
//   bus   : store_buffer_if.slave (store, load lookup, dmem write, status)
`timescale 1ns/1ps
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic          enq, deq;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    assign bus.st_ready = (count_q != CW'(DEPTH));
    assign bus.mem_we   = (count_q != '0);
    assign bus.empty    = (count_q == '0);
    assign bus.count    = count_q;
    // Head entry comes from registered state only, so a fresh store is never bypassed.
    assign bus.mem_addr = addr_q[head_q];
    assign bus.mem_wd   = data_q[head_q];
    assign bus.ld_hit   = fwd_hit;
    assign bus.ld_data  = fwd_data;

    assign enq = bus.st_valid & bus.st_ready;
    assign deq = bus.mem_we & bus.mem_ack;

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + PW'(1);
            if (deq) head_q <= head_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage is not cleared on reset; validity is derived from head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= bus.st_addr;
            data_q[tail_q] <= bus.st_data;
        end
    end

    // Walk valid entries oldest to youngest so the last match (youngest) wins.
    // The entry at head stays valid even while it is being dequeued this cycle.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head_q + PW'(i);
            if (i < int'(count_q) && addr_q[idx][AW-1:2] == bus.ld_addr[AW-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based model of the posted-write FIFO.
`timescale 1ns/1ps
module tb_store_buffer;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   model_on;
    entry_t model_q[$];

    store_buffer_if #(.DEPTH(DEPTH), .AW(32), .DW(32)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every output with the model queue, then apply this cycle's effect.
    task automatic step(input bit rst, input bit sv, input logic [31:0] sa,
                        input logic [31:0] sd, input logic [31:0] la, input bit ack);
        bit          exp_hit;
        logic [31:0] exp_ld;
        bit          do_deq;
        bit          do_enq;
        @(negedge clk);
        reset        = rst;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_addr  = la;
        bus.mem_ack  = ack;
        #1;
        if (model_on) begin
            exp_hit = 1'b0;
            exp_ld  = 32'h0;
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (model_q[i].addr[31:2] == la[31:2]) begin
                    exp_hit = 1'b1;
                    exp_ld  = model_q[i].data;
                    break;
                end
            end
            check_eq("count",    64'(bus.count),    64'(model_q.size()));
            check_eq("empty",    64'(bus.empty),    64'(model_q.size() == 0));
            check_eq("st_ready", 64'(bus.st_ready), 64'(model_q.size() != DEPTH));
            check_eq("mem_we",   64'(bus.mem_we),   64'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                check_eq("mem_addr", 64'(bus.mem_addr), 64'(model_q[0].addr));
                check_eq("mem_wd",   64'(bus.mem_wd),   64'(model_q[0].data));
            end
            check_eq("ld_hit",  64'(bus.ld_hit),  64'(exp_hit));
            check_eq("ld_data", 64'(bus.ld_data), 64'(exp_ld));
        end
        if (rst) begin
            model_q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            do_deq = ack && (model_q.size() != 0);
            do_enq = sv && (model_q.size() != DEPTH);
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back('{addr: sa, data: sd});
        end
    endtask

    task automatic idle(input bit ack, input logic [31:0] la);
        step(1'b0, 1'b0, 32'h0, 32'h0, la, ack);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        model_on     = 1'b0;
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_addr  = '0;
        bus.mem_ack  = 1'b0;

        // Reset held two cycles, then idle.
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        idle(1'b0, 32'h64);
        check_eq("rst_ready", 64'(bus.st_ready), 64'd1);
        check_eq("rst_empty", 64'(bus.empty), 64'd1);

        // Single store drains the cycle after acceptance.
        step(1'b0, 1'b1, 32'h64, 32'd7, 32'h0, 1'b1);
        idle(1'b1, 32'h0);
        check_eq("one_we",   64'(bus.mem_we), 64'd1);
        check_eq("one_addr", 64'(bus.mem_addr), 64'h64);
        check_eq("one_wd",   64'(bus.mem_wd), 64'd7);
        idle(1'b1, 32'h0);
        check_eq("one_cnt", 64'(bus.count), 64'd0);

        // Fill to full with ack low, fifth store held, then drain.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 32'h60 + 32'(i * 4), 32'(100 + i), 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h70, 32'd104, 32'h0, 1'b0);
        check_eq("full_ready", 64'(bus.st_ready), 64'd0);
        check_eq("full_cnt",   64'(bus.count), 64'd4);
        step(1'b0, 1'b1, 32'h70, 32'd104, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1, 32'h70);

        // Forwarding: youngest of two same-word stores wins, byte offset ignored.
        step(1'b0, 1'b1, 32'h60, 32'd1, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h60, 32'd2, 32'h60, 1'b0);
        idle(1'b0, 32'h62);
        check_eq("fwd_hit",  64'(bus.ld_hit), 64'd1);
        check_eq("fwd_data", 64'(bus.ld_data), 64'd2);
        idle(1'b0, 32'h68);
        check_eq("fwd_miss", 64'(bus.ld_hit), 64'd0);

        // count=2 with simultaneous store and ack.
        step(1'b0, 1'b1, 32'h80, 32'd3, 32'h80, 1'b1);
        idle(1'b0, 32'h80);
        check_eq("both_cnt", 64'(bus.count), 64'd2);

        // count=3 then reset mid-operation.
        step(1'b0, 1'b1, 32'h84, 32'd4, 32'h0, 1'b0);
        idle(1'b0, 32'h84);
        check_eq("pre_rst_cnt", 64'(bus.count), 64'd3);
        step(1'b1, 1'b0, 0, 0, 32'h84, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1, 32'h84);
        check_eq("post_rst_we", 64'(bus.mem_we), 64'd0);

        // Ten back-to-back stores with ack always high: pointers wrap.
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'(i * 17 + 5), 32'h200, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1, 32'h200);

        // Random traffic over a small address window so forwarding hits often.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 6),
                 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                 $urandom,
                 32'h100 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < ((n / 100) % 2 == 0 ? 3 : 7)));
        end
        idle(1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
